// File: rtl/rv32i_imem_sequencer.sv
// Instruction memory and run sequencer for an RV32I core: loads a program word by word,
// releases the core from reset, serves fetches and halts on end-of-program or a fault.
module rv32i_imem_sequencer #(
    parameter int unsigned DEPTH      = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0400_0000,
    parameter int unsigned MAX_CYCLES = 1024,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [31:0]              load_data,
    output logic                     load_ready,
    input  logic                     start,
    input  logic [31:0]              pc,
    output logic [31:0]              instruction,
    output logic                     core_rst,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   words_loaded,
    output logic [31:0]              retired_count,
    output logic                     done,
    output logic                     fault,
    output logic [1:0]               fault_code
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] MEM_END = BASE_ADDR + 32'(4 * DEPTH);
    localparam logic [31:0] TIMEOUT_AT = 32'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        StLoad = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } state_e;

    state_e        state_q;
    logic [31:0]   mem_q [DEPTH];
    logic [CW-1:0] words_loaded_q;
    logic [31:0]   retired_q;
    logic          done_q;
    logic          fault_q;
    logic [1:0]    code_q;

    logic          load_accept;
    logic [31:0]   prog_end;
    logic          misaligned;
    logic          out_of_range;
    logic          past_prog;
    logic          pc_valid;
    logic [AW-1:0] word_idx;

    assign load_ready  = (state_q == StLoad) && (words_loaded_q != CW'(DEPTH));
    assign load_accept = load_valid && load_ready;

    // Address checks are plain 32-bit unsigned; the parameters guarantee MEM_END does not wrap.
    assign prog_end     = BASE_ADDR + (32'(words_loaded_q) << 2);
    assign misaligned   = (pc[1:0] != 2'b00);
    assign out_of_range = (pc < BASE_ADDR) || (pc >= MEM_END);
    assign past_prog    = (pc >= prog_end);
    assign pc_valid     = !misaligned && (pc >= BASE_ADDR) && !past_prog;
    assign word_idx     = AW'((pc - BASE_ADDR) >> 2);

    assign instruction = ((state_q == StRun) && pc_valid) ? mem_q[word_idx] : NOP_WORD;

    assign core_rst      = (state_q != StRun);
    assign state         = state_q;
    assign words_loaded  = words_loaded_q;
    assign retired_count = retired_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign fault_code    = code_q;

    // Program storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            mem_q[words_loaded_q[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StLoad;
            words_loaded_q <= '0;
            retired_q      <= '0;
            done_q         <= 1'b0;
            fault_q        <= 1'b0;
            code_q         <= 2'b00;
        end else begin
            case (state_q)
                StLoad: begin
                    if (load_accept) begin
                        words_loaded_q <= words_loaded_q + CW'(1);
                    end
                    if (start && ((words_loaded_q != '0) || load_accept)) begin
                        state_q   <= StRun;
                        retired_q <= '0;
                        done_q    <= 1'b0;
                        fault_q   <= 1'b0;
                        code_q    <= 2'b00;
                    end
                end
                StRun: begin
                    // The halting cycle does not count as retired.
                    if (misaligned) begin
                        state_q <= StHalt;
                        fault_q <= 1'b1;
                        code_q  <= 2'b01;
                    end else if (out_of_range) begin
                        state_q <= StHalt;
                        fault_q <= 1'b1;
                        code_q  <= 2'b10;
                    end else if (past_prog) begin
                        state_q <= StHalt;
                        done_q  <= 1'b1;
                    end else if (retired_q == TIMEOUT_AT) begin
                        state_q <= StHalt;
                        fault_q <= 1'b1;
                        code_q  <= 2'b11;
                    end else begin
                        retired_q <= retired_q + 32'd1;
                    end
                end
                StHalt: begin
                    if (start) begin
                        state_q   <= StRun;
                        retired_q <= '0;
                        done_q    <= 1'b0;
                        fault_q   <= 1'b0;
                        code_q    <= 2'b00;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_imem_sequencer.sv
// Directed vector bench for rv32i_imem_sequencer with DEPTH=4 and MAX_CYCLES=8,
// plus a hand-written check that reset acts without a clock edge.
module tb_rv32i_imem_sequencer;

    localparam logic [31:0] B   = 32'h0400_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0]  LD  = 2'b00;
    localparam logic [1:0]  RN  = 2'b01;
    localparam logic [1:0]  HL  = 2'b10;
    localparam logic [31:0] WA  = 32'h0050_0093;
    localparam logic [31:0] WB  = 32'h00A0_0113;
    localparam logic [31:0] WC  = 32'h0020_81B3;
    localparam logic [31:0] WD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instruction;
    logic        core_rst;
    logic [1:0]  state;
    logic [2:0]  words_loaded;
    logic [31:0] retired_count;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32i_imem_sequencer #(
        .DEPTH      (4),
        .BASE_ADDR  (B),
        .MAX_CYCLES (8),
        .NOP_WORD   (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .start         (start),
        .pc            (pc),
        .instruction   (instruction),
        .core_rst      (core_rst),
        .state         (state),
        .words_loaded  (words_loaded),
        .retired_count (retired_count),
        .done          (done),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    typedef struct {
        logic        rst;
        logic        lv;
        logic [31:0] data;
        logic        st;
        logic [31:0] pc;
        logic [1:0]  est;
        int unsigned ewl;
        int unsigned eret;
        logic        edone;
        logic        efault;
        logic [1:0]  ecode;
        logic [31:0] einstr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic lv, input logic [31:0] d, input logic st,
                       input logic [31:0] p, input logic [1:0] es, input int unsigned ewl,
                       input int unsigned eret, input logic edn, input logic eft,
                       input logic [1:0] ec, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.lv = lv; v.data = d; v.st = st; v.pc = p; v.est = es;
        v.ewl = ewl; v.eret = eret; v.edone = edn; v.efault = eft; v.ecode = ec; v.einstr = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string tag, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", tag, idx, act, exp);
        end
    endtask

    initial begin
        // rst lv data st pc | state wl ret done fault code instr
        add(1, 0, 0,  0, 0,        LD, 0, 0, 0, 0, 2'd0, NOP);  // reset values
        add(0, 0, 0,  1, 0,        LD, 0, 0, 0, 0, 2'd0, NOP);  // start with nothing loaded
        add(0, 1, WA, 1, B,        RN, 1, 0, 0, 0, 2'd0, WA);   // load+start together
        add(1, 0, 0,  0, B,        LD, 0, 0, 0, 0, 2'd0, NOP);
        add(0, 1, WA, 0, B,        LD, 1, 0, 0, 0, 2'd0, NOP);
        add(0, 1, WB, 0, B,        LD, 2, 0, 0, 0, 2'd0, NOP);
        add(0, 1, WC, 0, B,        LD, 3, 0, 0, 0, 2'd0, NOP);
        add(0, 0, 0,  1, B,        RN, 3, 0, 0, 0, 2'd0, WA);
        add(0, 0, 0,  0, B,        RN, 3, 1, 0, 0, 2'd0, WA);
        add(0, 0, 0,  0, B + 4,    RN, 3, 2, 0, 0, 2'd0, WB);
        add(0, 0, 0,  0, B + 8,    RN, 3, 3, 0, 0, 2'd0, WC);
        add(0, 0, 0,  0, B + 12,   HL, 3, 3, 1, 0, 2'd0, NOP);  // end of program
        add(0, 0, 0,  0, B,        HL, 3, 3, 1, 0, 2'd0, NOP);  // HALT holds
        add(0, 0, 0,  1, B + 2,    RN, 3, 0, 0, 0, 2'd0, NOP);  // restart clears
        add(0, 0, 0,  0, B + 2,    HL, 3, 0, 0, 1, 2'd1, NOP);  // misaligned
        add(0, 0, 0,  1, 32'h0300_0000, RN, 3, 0, 0, 0, 2'd0, NOP);
        add(0, 0, 0,  0, 32'h0300_0000, HL, 3, 0, 0, 1, 2'd2, NOP);  // below base
        add(0, 0, 0,  1, B + 16,   RN, 3, 0, 0, 0, 2'd0, NOP);
        add(0, 0, 0,  0, B + 16,   HL, 3, 0, 0, 1, 2'd2, NOP);  // first address past memory
        add(0, 0, 0,  1, B + 12,   RN, 3, 0, 0, 0, 2'd0, NOP);
        add(0, 0, 0,  0, B + 12,   HL, 3, 0, 1, 0, 2'd0, NOP);  // immediate end
        add(0, 0, 0,  1, B,        RN, 3, 0, 0, 0, 2'd0, WA);
        for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, B, RN, 3, i, 0, 0, 2'd0, WA);
        add(0, 0, 0,  0, B,        HL, 3, 7, 0, 1, 2'd3, NOP);  // timeout
        add(0, 0, 0,  1, 32'h0300_0002, RN, 3, 0, 0, 0, 2'd0, NOP);
        add(0, 0, 0,  0, 32'h0300_0002, HL, 3, 0, 0, 1, 2'd1, NOP);  // misaligned beats range
        add(0, 1, WD, 0, B,        HL, 3, 0, 0, 1, 2'd1, NOP);  // load ignored in HALT
        add(1, 0, 0,  0, B,        LD, 0, 0, 0, 0, 2'd0, NOP);
        for (int i = 0; i < 6; i++)
            add(0, 1, 32'h1111_0000 + i, 0, B, LD, (i < 4) ? i + 1 : 4, 0, 0, 0, 2'd0, NOP);
        add(0, 0, 0,  1, B + 12,   RN, 4, 0, 0, 0, 2'd0, 32'h1111_0003);
        add(0, 0, 0,  0, B,        RN, 4, 1, 0, 0, 2'd0, 32'h1111_0000);
        add(0, 0, 0,  0, B + 4,    RN, 4, 2, 0, 0, 2'd0, 32'h1111_0001);
        add(0, 0, 0,  0, B + 16,   HL, 4, 2, 0, 1, 2'd2, NOP);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst        = vecs[k].rst;
            load_valid = vecs[k].lv;
            load_data  = vecs[k].data;
            start      = vecs[k].st;
            pc         = vecs[k].pc;
            @(posedge clk);
            #1;
            check("state", k, 32'(state), 32'(vecs[k].est));
            check("load_ready", k, 32'(load_ready),
                  32'((vecs[k].est == LD) && (vecs[k].ewl < 4)));
            check("core_rst", k, 32'(core_rst), 32'(vecs[k].est != RN));
            check("words_loaded", k, 32'(words_loaded), vecs[k].ewl);
            check("retired_count", k, retired_count, vecs[k].eret);
            check("done", k, 32'(done), 32'(vecs[k].edone));
            check("fault", k, 32'(fault), 32'(vecs[k].efault));
            check("fault_code", k, 32'(fault_code), 32'(vecs[k].ecode));
            check("instruction", k, instruction, vecs[k].einstr);
        end

        // Reset in the middle of a RUN cycle must act before the next clock edge.
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b1;
        pc         = B;
        @(posedge clk);
        #1;
        check("async_pre_state", 900, 32'(state), 32'(RN));
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_state", 901, 32'(state), 32'(LD));
        check("async_core_rst", 901, 32'(core_rst), 32'd1);
        check("async_words", 901, 32'(words_loaded), 32'd0);
        check("async_load_ready", 901, 32'(load_ready), 32'd1);
        check("async_instr", 901, instruction, NOP);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_after_reset", 902, 32'(state), 32'(LD));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_imem_sequencer.md
RV32I_IMEM_SEQUENCER -- requirements
Module: rv32i_imem_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 64: instruction words held (power of two, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0400_0000: byte address of word 0.
REQ-003 SHALL have parameter MAX_CYCLES, default 1024: RUN cycles before timeout fault.
REQ-004 SHALL have parameter NOP_WORD, default 32'h0000_0013: word returned outside the valid program.
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port load_valid, input, 1: load_data is valid.
REQ-008 SHALL have port load_data, input, 32: program word, loaded in ascending address order.
REQ-009 SHALL have port load_ready, output, 1: a word is accepted when load_valid&&load_ready.
REQ-010 SHALL have port start, input, 1: request to begin or restart execution.
REQ-011 SHALL have port pc, input, 32: core program counter (byte address).
REQ-012 SHALL have port instruction, output, 32: fetched instruction word.
REQ-013 SHALL have port core_rst, output, 1: holds the core in reset, active-high.
REQ-014 SHALL have port state, output, 2: LOAD=00, RUN=01, HALT=10 (11 unused).
REQ-015 SHALL have port words_loaded, output, $clog2(DEPTH)+1: program length in words.
REQ-016 SHALL have port retired_count, output, 32: RUN cycles since the last entry to RUN.
REQ-017 SHALL have port done, output, 1: normal end of program reached.
REQ-018 SHALL have port fault, output, 1: abnormal halt.
REQ-019 SHALL have port fault_code, output, 2: 00 none, 01 misaligned, 10 out-of-range, 11 timeout.

Function
REQ-020 Reset values SHALL be: state=LOAD, load_ready=1, core_rst=1, words_loaded=0, retired_count=0, done=0, fault=0, fault_code=00, instruction=NOP_WORD; memory contents are not reset.
REQ-021 In LOAD, load_ready SHALL be 1 while words_loaded<DEPTH; each accepted word SHALL be written to mem[words_loaded] and words_loaded SHALL increment in the same edge.
REQ-022 With words_loaded==DEPTH, load_ready SHALL be 0 and load_valid SHALL be ignored.
REQ-023 In RUN and HALT, load_ready SHALL be 0.
REQ-024 In LOAD, start SHALL move to RUN on the next edge only if words_loaded>0 or a word is accepted on that same edge; otherwise start is ignored.
REQ-025 On simultaneous load and start in LOAD, the word SHALL be written and counted before RUN begins.
REQ-026 On every entry to RUN, retired_count SHALL clear to 0 and done, fault and fault_code SHALL clear.
REQ-027 core_rst SHALL be 0 exactly while state==RUN, and 1 otherwise.
REQ-028 In RUN, instruction SHALL be combinational: mem[(pc-BASE_ADDR)>>2] when pc is a valid program address, else NOP_WORD; in LOAD and HALT it SHALL be NOP_WORD.
REQ-029 A valid program address SHALL satisfy: pc[1:0]==0, pc>=BASE_ADDR, and pc<BASE_ADDR+4*words_loaded.
REQ-030 In RUN, retired_count SHALL increment by 1 per cycle.
REQ-031 In RUN, the halt check SHALL be evaluated each cycle and SHALL use priority misaligned > out-of-range > end > timeout.
REQ-032 Misaligned halt: pc[1:0]!=0 SHALL cause fault=1, fault_code=01, HALT next edge.
REQ-033 Out-of-range halt: pc<BASE_ADDR or pc>=BASE_ADDR+4*DEPTH SHALL cause fault=1, fault_code=10, HALT.
REQ-034 End halt: pc in [BASE_ADDR+4*words_loaded, BASE_ADDR+4*DEPTH) SHALL cause done=1, fault=0, HALT.
REQ-035 Timeout halt: retired_count==MAX_CYCLES-1 with no other halt SHALL cause fault=1, fault_code=11, HALT.
REQ-036 In HALT, done, fault, fault_code and retired_count SHALL hold; start SHALL re-enter RUN with the same program.
REQ-037 Address arithmetic SHALL be 32-bit unsigned; BASE_ADDR+4*DEPTH SHALL not wrap, which is a parameter legality rule.

Reset
REQ-038 Asserting rst in any state, including mid-RUN or mid-LOAD, SHALL asynchronously force the REQ-020 values; the program SHALL be reloaded before the next RUN.

Verification
REQ-039 Load 3 words (A,B,C), then assert start -> state=RUN, core_rst=0; pc=0x0400_0004 yields B; pc=0x0400_000C -> done=1, state=HALT, retired_count=3 if pc stepped by 4 from BASE.
REQ-040 In LOAD with 0 words loaded, assert start alone -> state stays LOAD; then load_valid+start on the same cycle -> words_loaded=1, state=RUN.
REQ-041 DEPTH=4: offer 6 words -> exactly 4 accepted, load_ready=0 after the 4th, words_loaded=4.
REQ-042 In RUN, drive pc=0x0400_0002 -> fault=1, fault_code=01; pc=0x0300_0000 -> fault_code=10; pc held at BASE with MAX_CYCLES=8 -> fault_code=11, retired_count=7.
REQ-043 Assert rst mid-RUN -> immediate state=LOAD, core_rst=1, words_loaded=0; start from HALT -> RUN with retired_count=0 and flags cleared.
